// File: rtl/io_bridge_pkg.sv
// Shared definitions for the CPU I/O bridge: the I/O address map, the
// seven-segment pattern table and the display reset values.
package io_bridge_pkg;

  localparam logic [31:0] AddrDig   = 32'hFFFF_F000;
  localparam logic [31:0] AddrTimer = 32'hFFFF_F020;
  localparam logic [31:0] AddrLed   = 32'hFFFF_F060;
  localparam logic [31:0] AddrSw    = 32'hFFFF_F070;
  localparam logic [31:0] AddrBtn   = 32'hFFFF_F078;

  localparam logic [7:0] DigEnRst = 8'hFE;
  localparam logic [7:0] SegRst   = 8'hC0;

  typedef enum logic [2:0] {
    SelDram,
    SelDig,
    SelTimer,
    SelLed,
    SelSw,
    SelBtn
  } bus_sel_e;

  // Takes the word address (byte address bits [31:2]).
  function automatic bus_sel_e decode_addr(input logic [29:0] waddr);
    bus_sel_e sel;
    sel = SelDram;
    if (waddr == AddrDig[31:2])   sel = SelDig;
    if (waddr == AddrTimer[31:2]) sel = SelTimer;
    if (waddr == AddrLed[31:2])   sel = SelLed;
    if (waddr == AddrSw[31:2])    sel = SelSw;
    if (waddr == AddrBtn[31:2])   sel = SelBtn;
    return sel;
  endfunction

  // Active-low {dp,g,f,e,d,c,b,a}; dp stays off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      default: pat = 8'h8E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/io_bridge_seg_scan.sv
// Multiplexed 8-digit seven-segment scanner: each digit is lit for SCAN_DIV
// cycles, rightmost first; outputs are registered.
module seg_scan
  import io_bridge_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] value,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      dig_en_q, dig_en_d;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      nib;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_cnt_q == DivW'(SCAN_DIV - 1)) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 3'd1;
    end
    // Outputs follow the current digit one edge later, so a value change
    // shows up without disturbing the scan position.
    nib      = value[{idx_q, 2'b00} +: 4];
    dig_en_d = ~(8'b1 << idx_q);
    seg_d    = hex_to_seg(nib);
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      dig_en_q  <= DigEnRst;
      seg_q     <= SegRst;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      dig_en_q  <= dig_en_d;
      seg_q     <= seg_d;
    end
  end

  assign dig_en = dig_en_q;
  assign seg    = seg_q;

endmodule

// File: rtl/io_bridge.sv
// Data-bus responder: routes each CPU access to DRAM or to the on-board
// peripherals (display, LEDs, switches, buttons, timer).
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 20000,
  parameter int unsigned DRAM_AW  = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic [31:0]        dram_wdata,
  output logic               dram_we,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         button,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         seg
);

  bus_sel_e    sel;
  logic [23:0] led_q, led_d;
  logic [31:0] dig_q, dig_d;
  logic [31:0] timer_q, timer_d;
  logic [23:0] sw_meta_q, sw_sync_q;
  logic [4:0]  btn_meta_q, btn_sync_q;
  logic        unused_addr;

  assign sel         = decode_addr(Bus_addr[31:2]);
  assign unused_addr = ^Bus_addr[1:0];

  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wdata = Bus_wdata;
  assign dram_we    = Bus_wen && (sel == SelDram);

  always_comb begin
    led_d   = led_q;
    dig_d   = dig_q;
    timer_d = timer_q + 32'd1;
    if (Bus_wen) begin
      if (sel == SelLed)   led_d   = Bus_wdata[23:0];
      if (sel == SelDig)   dig_d   = Bus_wdata;
      if (sel == SelTimer) timer_d = Bus_wdata;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      led_q      <= '0;
      dig_q      <= '0;
      timer_q    <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      led_q      <= led_d;
      dig_q      <= dig_d;
      timer_q    <= timer_d;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= button;
      btn_sync_q <= btn_meta_q;
    end
  end

  always_comb begin
    Bus_rdata = dram_rdata;
    unique case (sel)
      SelDig:   Bus_rdata = dig_q;
      SelTimer: Bus_rdata = timer_q;
      SelLed:   Bus_rdata = {8'b0, led_q};
      SelSw:    Bus_rdata = {8'b0, sw_sync_q};
      SelBtn:   Bus_rdata = {27'b0, btn_sync_q};
      default:  Bus_rdata = dram_rdata;
    endcase
  end

  assign led = led_q;

  seg_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_seg_scan (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .value  (dig_q),
    .dig_en (dig_en),
    .seg    (seg)
  );

endmodule

// File: tb/tb_io_bridge.sv
// Bench for io_bridge: a cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_io_bridge;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned DramAw  = 14;

  logic              cpu_clk = 1'b0;
  logic              cpu_rst;
  logic [31:0]       Bus_addr;
  logic              Bus_wen;
  logic [31:0]       Bus_wdata;
  logic [31:0]       Bus_rdata;
  logic [DramAw-1:0] dram_addr;
  logic [31:0]       dram_wdata;
  logic              dram_we;
  logic [31:0]       dram_rdata;
  logic [23:0]       sw;
  logic [4:0]        button;
  logic [23:0]       led;
  logic [7:0]        dig_en;
  logic [7:0]        seg;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  io_bridge #(
    .SCAN_DIV(ScanDiv),
    .DRAM_AW (DramAw)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .Bus_addr  (Bus_addr),
    .Bus_wen   (Bus_wen),
    .Bus_wdata (Bus_wdata),
    .Bus_rdata (Bus_rdata),
    .dram_addr (dram_addr),
    .dram_wdata(dram_wdata),
    .dram_we   (dram_we),
    .dram_rdata(dram_rdata),
    .sw        (sw),
    .button    (button),
    .led       (led),
    .dig_en    (dig_en),
    .seg       (seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  // DRAM stand-in: recognisable pattern tagged with the word address.
  assign dram_rdata = {18'h2B3C5, dram_addr};

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scan position derived from edges elapsed since reset.
  logic [23:0] m_led;
  logic [31:0] m_dig, m_timer;
  logic [23:0] m_sw1, m_sw2;
  logic [4:0]  m_btn1, m_btn2;
  logic [7:0]  m_dig_en, m_seg;
  int unsigned m_edges;

  always @(posedge cpu_clk or posedge cpu_rst) begin
    int unsigned k;
    if (cpu_rst) begin
      m_led = '0; m_dig = '0; m_timer = '0;
      m_sw1 = '0; m_sw2 = '0; m_btn1 = '0; m_btn2 = '0;
      m_dig_en = 8'hFE; m_seg = 8'hC0; m_edges = 0;
    end else begin
      k        = (m_edges / ScanDiv) % 8;
      m_dig_en = ~(8'h01 << k);
      m_seg    = hex_tab[m_dig[4*k +: 4]];
      m_edges++;
      m_sw2 = m_sw1; m_sw1 = sw;
      m_btn2 = m_btn1; m_btn1 = button;
      m_timer = m_timer + 32'd1;
      if (Bus_wen) begin
        case ({Bus_addr[31:2], 2'b00})
          32'hFFFF_F000: m_dig = Bus_wdata;
          32'hFFFF_F020: m_timer = Bus_wdata;
          32'hFFFF_F060: m_led = Bus_wdata[23:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    case ({a[31:2], 2'b00})
      32'hFFFF_F000: return m_dig;
      32'hFFFF_F020: return m_timer;
      32'hFFFF_F060: return {8'b0, m_led};
      32'hFFFF_F070: return {8'b0, m_sw2};
      32'hFFFF_F078: return {27'b0, m_btn2};
      default:       return {18'h2B3C5, a[15:2]};
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return w == 32'hFFFF_F000 || w == 32'hFFFF_F020 || w == 32'hFFFF_F060 ||
           w == 32'hFFFF_F070 || w == 32'hFFFF_F078;
  endfunction

  always @(posedge cpu_clk) begin
    #1;
    if (!cpu_rst) begin
      check("led", {8'b0, led}, {8'b0, m_led});
      check("dig_en", {24'b0, dig_en}, {24'b0, m_dig_en});
      check("seg", {24'b0, seg}, {24'b0, m_seg});
      check("rdata", Bus_rdata, exp_rdata(Bus_addr));
      check("dram_we", {31'b0, dram_we}, {31'b0, Bus_wen && !is_io(Bus_addr)});
      check("dram_addr", {18'b0, dram_addr}, {18'b0, Bus_addr[15:2]});
      check("dram_wdata", dram_wdata, Bus_wdata);
    end
  end

  task automatic bus(input logic wen, input logic [31:0] a, input logic [31:0] d);
    @(negedge cpu_clk);
    Bus_wen = wen; Bus_addr = a; Bus_wdata = d;
    #1;
  endtask

  task automatic wait_digen(input logic [7:0] tgt, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge cpu_clk);
      #1;
      if (dig_en == tgt) begin
        cycles = i;
        return;
      end
    end
  endtask

  logic [7:0] step_en  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] step_seg [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  initial begin
    int cyc;
    cpu_rst = 1'b1; Bus_wen = 1'b0; Bus_addr = '0; Bus_wdata = '0;
    sw = '0; button = '0;
    repeat (3) @(negedge cpu_clk);
    cpu_rst = 1'b0;
    #1;
    check("rst_led", {8'b0, led}, 32'h0);
    check("rst_dig_en", {24'b0, dig_en}, 32'hFE);
    check("rst_seg", {24'b0, seg}, 32'hC0);

    // DRAM write and read-through
    bus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    check("t1_dram_we", {31'b0, dram_we}, 32'h1);
    check("t1_dram_addr", {18'b0, dram_addr}, 32'h4);
    bus(1'b0, 32'h0000_0010, 32'h0);
    check("t1_rdata", Bus_rdata, 32'hACF1_4004);
    check("t1_led", {8'b0, led}, 32'h0);

    // LED write
    bus(1'b1, 32'hFFFF_F060, 32'hAB12_3456);
    check("t2_dram_we", {31'b0, dram_we}, 32'h0);
    bus(1'b0, 32'hFFFF_F063, 32'h0);
    check("t2_led", {8'b0, led}, 32'h0012_3456);
    check("t2_rdata", Bus_rdata, 32'h0012_3456);

    // Switch / button synchronizer latency
    @(negedge cpu_clk);
    sw = 24'h00A5A5; Bus_wen = 1'b0; Bus_addr = 32'hFFFF_F070;
    #1 check("t3_sw_e0", Bus_rdata, 32'h0);
    @(negedge cpu_clk); #1 check("t3_sw_e1", Bus_rdata, 32'h0);
    @(negedge cpu_clk); #1 check("t3_sw_e2", Bus_rdata, 32'h0000_A5A5);
    button = 5'h13;
    bus(1'b1, 32'hFFFF_F078, 32'hFFFF_FFFF);
    @(negedge cpu_clk); #1 check("t3_btn", Bus_rdata, 32'h0000_0013);
    bus(1'b1, 32'hFFFF_F070, 32'h0);
    check("t3_sw_ro", Bus_rdata, 32'h0000_A5A5);

    // Timer load and wrap
    bus(1'b1, 32'hFFFF_F020, 32'hFFFF_FFFE);
    bus(1'b0, 32'hFFFF_F020, 32'h0);
    check("t4_v", Bus_rdata, 32'hFFFF_FFFE);
    @(negedge cpu_clk); #1 check("t4_v1", Bus_rdata, 32'hFFFF_FFFF);
    @(negedge cpu_clk); #1 check("t4_wrap", Bus_rdata, 32'h0);

    // Display scan
    bus(1'b1, 32'hFFFF_F000, 32'h7654_3210);
    bus(1'b0, 32'hFFFF_F000, 32'h0);
    wait_digen(8'hFE, 40, cyc);
    check("t5_first_fe", 32'(cyc > 0), 32'h1);
    check("t5_seg0", {24'b0, seg}, {24'b0, step_seg[0]});
    for (int k = 1; k <= 8; k++) begin
      wait_digen(step_en[k % 8], 2 * ScanDiv, cyc);
      check("t5_step_len", 32'(cyc), 32'(ScanDiv));
      check("t5_seg", {24'b0, seg}, {24'b0, step_seg[k % 8]});
    end
    // Mid-scan DIG writes, including ones that land on a digit wrap
    for (int k = 0; k < 6; k++) bus(1'b1, 32'hFFFF_F000, 32'hFEDC_BA98 + 32'(k));
    bus(1'b0, 32'h0000_0200, 32'h0);
    repeat (20) @(negedge cpu_clk);

    // Async reset mid-scan with a pending LED write
    wait_digen(8'hDF, 8 * ScanDiv + 4, cyc);
    check("t6_reach_idx5", 32'(cyc > 0), 32'h1);
    bus(1'b1, 32'hFFFF_F060, 32'h00FF_FFFF);
    #2 cpu_rst = 1'b1;
    #1;
    check("t6_led", {8'b0, led}, 32'h0);
    check("t6_dig_en", {24'b0, dig_en}, 32'hFE);
    check("t6_seg", {24'b0, seg}, 32'hC0);
    Bus_addr = 32'hFFFF_F020; Bus_wen = 1'b0;
    #1 check("t6_timer", Bus_rdata, 32'h0);
    Bus_addr = 32'hFFFF_F060; Bus_wen = 1'b1;
    @(negedge cpu_clk);
    cpu_rst = 1'b0; Bus_wen = 1'b0;
    #1 check("t6_write_lost", {8'b0, led}, 32'h0);
    repeat (ScanDiv + 3) @(negedge cpu_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Responder end of the CPU data-bus interface (`Bus_addr` / `Bus_wen` / `Bus_wdata` / `Bus_rdata`).
- Decodes each access to either the DRAM or one of the on-board peripherals: 8-digit seven-segment display, LEDs, switches, buttons and a free-running timer.
- Sits between the CPU core's MEM stage and the DRAM/board pins.
- Owns all peripheral state and the display scan logic.

Parameters:
- SCAN_DIV, 20000: cpu_clk cycles each display digit stays lit; must be >= 2.
- DRAM_AW, 14: DRAM word-address width.

Ports:
- cpu_clk  in  1  system clock; all state updates on rising edge
- cpu_rst  in  1  reset, asynchronous, active-high
- Bus_addr  in  32  byte address from CPU MEM stage
- Bus_wen  in  1  write enable for the current access
- Bus_wdata  in  32  write data
- Bus_rdata  out  32  read data, combinational, same cycle as Bus_addr
- dram_addr  out  DRAM_AW  word address = Bus_addr[DRAM_AW+1:2]
- dram_wdata  out  32  = Bus_wdata
- dram_we  out  1  DRAM write strobe
- dram_rdata  in  32  DRAM combinational read data
- sw  in  24  board switches, asynchronous to cpu_clk
- button  in  5  board buttons, asynchronous to cpu_clk
- led  out  24  LED outputs, 1 = lit
- dig_en  out  8  digit enables, active-low
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Address map: compare Bus_addr[31:2] exactly; bits [1:0] are ignored.
  - DIG = 0xFFFF_F000
  - TIMER = 0xFFFF_F020
  - LED = 0xFFFF_F060
  - SW = 0xFFFF_F070
  - BTN = 0xFFFF_F078
  - Any other address maps to DRAM.
- Write rules:
  - dram_we = Bus_wen AND address hits DRAM; it is never asserted for an I/O address.
  - Writes to I/O registers take effect on the rising edge while Bus_wen = 1.
  - SW/BTN writes are ignored.
- Read mux (combinational, zero latency):
  - DIG: dig_reg
  - TIMER: timer
  - LED: {8'b0, led_reg}
  - SW: {8'b0, sw_sync}
  - BTN: {27'b0, btn_sync}
  - DRAM: dram_rdata
- sw and button each pass through a two-flop synchronizer. A pin change is visible on reads 2 edges later.
- LED register: a write loads Bus_wdata[23:0]; led = led_reg.
- DIG register: a write loads all 32 bits. Nibble k (bits 4k+3:4k) is shown on digit k; digit 0 is rightmost.
- Timer:
  - 32-bit counter, +1 every cycle.
  - Wraps 0xFFFF_FFFF -> 0.
  - A write loads Bus_wdata, and the write wins over the increment. The value read the cycle after a write of V is V; one cycle later it is V+1.
- Display scanner:
  - div_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On the wrap, digit index idx (3 bits) increments mod 8; 7 -> 0.
  - dig_en = ~(8'b1 << idx), registered.
  - seg = hex_to_seg(dig_reg nibble idx), registered; dp is always 1 (off).
  - A DIG write mid-scan changes the displayed segments from the next edge; idx and div_cnt are not disturbed.
- Hex pattern (active-low, 0..F): C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Reset (async, any time, including mid-write or mid-scan):
  - led_reg = 0, dig_reg = 0, timer = 0
  - sync flops = 0, div_cnt = 0, idx = 0
  - dig_en = 8'hFE, seg = 8'hC0, led = 0
  - A write in the reset cycle is discarded.
- Simultaneous events:
  - Only one bus access per cycle.
  - Scan wrap and DIG write in the same cycle: both apply.
  - Timer wrap and timer write in the same cycle: the write wins.

Decomposition:
- Shared package holds:
  - I/O address constants (DIG/TIMER/LED/SW/BTN)
  - the 16-entry seven-segment pattern table / hex_to_seg function
  - the reset constants for dig_en and seg
- One sub-module: seg_scan. Inputs: cpu_clk, cpu_rst, 32-bit value. Outputs: dig_en, seg. Parameter: SCAN_DIV.

Test Plan:
1. Reset, then Bus_wen=1, addr 0x0000_0010, wdata 0xDEAD_BEEF -> dram_we=1, dram_addr=4, led unchanged. Next read of addr 0x10 returns dram_rdata.
2. Write LED 0xFFFF_F060 with 0xAB12_3456 -> dram_we=0 that cycle; led=0x123456 after the edge; read returns 0x0012_3456.
3. Drive sw=0x00A5A5 -> a read of 0xFFFF_F070 returns 0 at edges 0 and 1, and 0x0000_A5A5 from edge 2.
4. Write TIMER 0xFFFF_FFFE, then idle -> reads return 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles.
5. SCAN_DIV=4: write DIG 0x7654_3210 -> dig_en steps FE, FD, FB, ... every 4 cycles with seg C0, F9, A4, ...; after digit 7 (dig_en 7F, seg F8) it returns to FE.
6. Assert cpu_rst asynchronously mid-scan, with idx=5 and a LED write pending -> outputs immediately go to led=0, dig_en=FE, seg=C0, timer=0; the pending write is lost.
